mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory port between the CPU instruction-fetch channel and the CPU data (load/store) channel.
- Sits between the multi-cycle CPU core and the single-ported memory/bus bridge.
- Arbitrates requests with data priority and an anti-starvation limit, then steers responses back to the owning requester.
- Holds one outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending; range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_valid  in  1  fetch request valid
- i_addr  in  ADDR_WIDTH  fetch address
- i_req_ready  out  1  fetch request accepted
- i_rdata  out  DATA_WIDTH  fetched instruction
- i_rdata_valid  out  1  fetch response valid
- i_rdata_ready  in  1  core accepts fetch response
- d_req_valid  in  1  data request valid (read or write)
- d_wen  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  word-aligned data address
- d_wdata  in  DATA_WIDTH  store data
- d_wstrb  in  DATA_WIDTH/8  store byte strobes
- d_req_ready  out  1  data request accepted
- d_rdata  out  DATA_WIDTH  load data
- d_rdata_valid  out  1  load response valid
- d_rdata_ready  in  1  core accepts load response
- m_req_valid  out  1  memory request valid
- m_wen  out  1  memory write enable
- m_addr  out  ADDR_WIDTH  memory address
- m_wdata  out  DATA_WIDTH  memory write data
- m_wstrb  out  DATA_WIDTH/8  memory byte strobes
- m_req_ready  in  1  memory accepts request
- m_rdata  in  DATA_WIDTH  memory read data
- m_rdata_valid  in  1  memory read data valid
- m_rdata_ready  out  1  arbiter accepts read data

Behaviour:
- Reset: clk and rst are already decided. One clock; reset is synchronous and active-high.
  - On reset: state=IDLE, owner=none, starve_cnt=0.
  - All valid and ready outputs are 0.
  - m_addr, m_wdata and m_wstrb are 0.
- One-hot FSM with states IDLE, IREQ, IRESP, DREQ, DRESP.
- IDLE:
  - No requester is acknowledged.
  - If d_req_valid and either !i_req_valid or starve_cnt < STARVE_LIMIT, go to DREQ.
  - Else if i_req_valid, go to IREQ.
  - Else stay in IDLE.
  - Arbitration costs exactly 1 cycle.
- IREQ:
  - m_req_valid=1, m_wen=0, m_addr=i_addr, m_wstrb=0.
  - i_req_ready=m_req_ready (combinational).
  - On m_req_ready, go to IRESP.
- IRESP:
  - i_rdata_valid=m_rdata_valid, i_rdata=m_rdata, m_rdata_ready=i_rdata_ready.
  - When m_rdata_valid & i_rdata_ready, go to IDLE.
- DREQ:
  - m_req_valid=1; m_wen, m_addr, m_wdata and m_wstrb pass through from the d_* inputs.
  - d_req_ready=m_req_ready.
  - On m_req_ready: a write (d_wen=1) goes to IDLE with no response phase; a read goes to DRESP.
- DRESP:
  - Same as IRESP, using the d_* response signals.
- Passive signals: outside its owning state, every response/ready output is 0 and m_rdata_ready is 0.
- Requester inputs are sampled live in xREQ states. Requesters must hold them stable until accepted.
- starve_cnt (4 bits):
  - Increments on each DREQ acceptance while i_req_valid=1, saturating at 15.
  - Clears on IREQ acceptance, or on DREQ acceptance with i_req_valid=0.
- Simultaneous requests with starve_cnt=STARVE_LIMIT: the fetch wins.
- A request withdrawn in IDLE before the FSM leaves IDLE is simply not granted.
- Reset mid-transaction: immediate return to IDLE and the in-flight transaction is abandoned. The memory side shares the same rst.
- Latency: a read completes no earlier than 3 cycles after request (IDLE, xREQ, xRESP), with zero-wait memory.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN
- Enabled:
  - Adds outputs perf_i_grant [31:0], perf_d_grant [31:0] and perf_conflict [31:0].
  - perf_i_grant and perf_d_grant count request acceptances per channel.
  - perf_conflict counts cycles in which a requester has valid high but the FSM is not in its xREQ state.
  - All three counters reset to 0 and wrap at 2^32.
- Disabled: the ports and counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- Fetch only, i_addr=0x100, memory ready at once, m_rdata=0x2402000A: i_req_ready is high in the 2nd cycle, i_rdata_valid is high in the 3rd with data 0x2402000A, then IDLE.
- Store d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=4'b1111, with m_req_ready delayed 3 cycles: m_req_valid is held for 4 cycles, and the FSM returns to IDLE with no d_rdata_valid pulse.
- Fetch and load requested together, starve_cnt=0: the load is served first (m_addr=d_addr), then the fetch.
- Continuous data requests with i_req_valid held, STARVE_LIMIT=4: after 4 data grants the 5th grant goes to the fetch, and starve_cnt clears.
- Load in DRESP, rst asserted for 1 cycle: all outputs are 0 in the next cycle, the FSM is in IDLE, and a new fetch is granted normally.
- With MEM_ARB_PERF_CNT_EN defined, run 3 fetches and 2 loads back to back: perf_i_grant=3, perf_d_grant=2, and perf_conflict is nonzero.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between CPU fetch and data channels with
//            data priority, anti-starvation limit and one outstanding txn.
//            Optional performance counters: define MEM_ARB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_req_ready,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_rdata_valid,
    input  logic                    i_rdata_ready,
    input  logic                    d_req_valid,
    input  logic                    d_wen,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_req_ready,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_rdata_valid,
    input  logic                    d_rdata_ready,
    output logic                    m_req_valid,
    output logic                    m_wen,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_req_ready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_rdata_valid,
    output logic                    m_rdata_ready
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]             perf_i_grant,
    output logic [31:0]             perf_d_grant,
    output logic [31:0]             perf_conflict
`endif
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_IREQ  = 5'b00010,
        S_IRESP = 5'b00100,
        S_DREQ  = 5'b01000,
        S_DRESP = 5'b10000
    } state_t;

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        i_req_ready   = 1'b0;
        i_rdata       = '0;
        i_rdata_valid = 1'b0;
        d_req_ready   = 1'b0;
        d_rdata       = '0;
        d_rdata_valid = 1'b0;
        m_req_valid   = 1'b0;
        m_wen         = 1'b0;
        m_addr        = '0;
        m_wdata       = '0;
        m_wstrb       = '0;
        m_rdata_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Data wins unless a fetch has waited through STARVE_LIMIT data grants.
                if (d_req_valid && (!i_req_valid || (starve_cnt_q < C_STARVE_LIMIT)))
                    state_d = S_DREQ;
                else if (i_req_valid)
                    state_d = S_IREQ;
            end
            S_IREQ: begin
                m_req_valid = 1'b1;
                m_addr      = i_addr;
                i_req_ready = m_req_ready;
                if (m_req_ready) begin
                    state_d      = S_IRESP;
                    starve_cnt_d = 4'd0;
                end
            end
            S_IRESP: begin
                i_rdata_valid = m_rdata_valid;
                i_rdata       = m_rdata;
                m_rdata_ready = i_rdata_ready;
                if (m_rdata_valid && i_rdata_ready)
                    state_d = S_IDLE;
            end
            S_DREQ: begin
                m_req_valid = 1'b1;
                m_wen       = d_wen;
                m_addr      = d_addr;
                m_wdata     = d_wdata;
                m_wstrb     = d_wstrb;
                d_req_ready = m_req_ready;
                if (m_req_ready) begin
                    state_d = d_wen ? S_IDLE : S_DRESP;
                    if (!i_req_valid)
                        starve_cnt_d = 4'd0;
                    else if (starve_cnt_q != 4'hF)
                        starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end
            S_DRESP: begin
                d_rdata_valid = m_rdata_valid;
                d_rdata       = m_rdata;
                m_rdata_ready = d_rdata_ready;
                if (m_rdata_valid && d_rdata_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_i_grant_q, perf_i_grant_d;
    logic [31:0] perf_d_grant_q, perf_d_grant_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;

    always_comb begin
        perf_i_grant_d  = perf_i_grant_q;
        perf_d_grant_d  = perf_d_grant_q;
        perf_conflict_d = perf_conflict_q;
        if (state_q == S_IREQ && m_req_ready)
            perf_i_grant_d = perf_i_grant_q + 32'd1;
        if (state_q == S_DREQ && m_req_ready)
            perf_d_grant_d = perf_d_grant_q + 32'd1;
        if ((i_req_valid && state_q != S_IREQ) || (d_req_valid && state_q != S_DREQ))
            perf_conflict_d = perf_conflict_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_grant_q  <= 32'd0;
            perf_d_grant_q  <= 32'd0;
            perf_conflict_q <= 32'd0;
        end else begin
            perf_i_grant_q  <= perf_i_grant_d;
            perf_d_grant_q  <= perf_d_grant_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_i_grant  = perf_i_grant_q;
    assign perf_d_grant  = perf_d_grant_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_rdata_valid, i_rdata_ready;
    logic [31:0] i_addr, i_rdata;
    logic        d_req_valid, d_wen, d_req_ready, d_rdata_valid, d_rdata_ready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        m_req_valid, m_wen, m_req_ready, m_rdata_valid, m_rdata_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_i_grant, perf_d_grant, perf_conflict;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_addr(i_addr), .i_req_ready(i_req_ready),
        .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready),
        .d_req_valid(d_req_valid), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_req_ready(d_req_ready), .d_rdata(d_rdata),
        .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready),
        .m_req_valid(m_req_valid), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_req_ready(m_req_ready), .m_rdata(m_rdata),
        .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_i_grant(perf_i_grant), .perf_d_grant(perf_d_grant),
        .perf_conflict(perf_conflict)
`endif
    );

    // Advance to the next low phase; inputs change here, then outputs settle.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_req_valid = 0; i_addr = 0; i_rdata_ready = 1;
        d_req_valid = 0; d_wen = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; d_rdata_ready = 1;
        m_req_ready = 0; m_rdata = 0; m_rdata_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        i_req_valid = 1; d_req_valid = 1; m_req_ready = 1; m_rdata_valid = 1;
        step(); step(); #1;
        checks++; if ({m_req_valid, i_req_ready, d_req_ready, i_rdata_valid, d_rdata_valid, m_rdata_ready} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=000000", {m_req_valid, i_req_ready, d_req_ready, i_rdata_valid, d_rdata_valid, m_rdata_ready}); end
        checks++; if ({m_addr, m_wdata, m_wstrb} !== 68'h0) begin
            failures++; $display("FAIL reset_mbus got=%h exp=0", {m_addr, m_wdata, m_wstrb}); end
        idle_inputs();
        step();
        rst = 0;
    endtask

    task automatic test_fetch();
        i_req_valid = 1; i_addr = 32'h100; m_req_ready = 1;
        m_rdata = 32'h2402000A; m_rdata_valid = 1; i_rdata_ready = 1;
        #1;
        checks++; if ({m_req_valid, i_req_ready, i_rdata_valid} !== 3'b000) begin
            failures++; $display("FAIL fetch_idle got=%b exp=000", {m_req_valid, i_req_ready, i_rdata_valid}); end
        step(); #1;
        checks++; if ({m_req_valid, i_req_ready, m_wen, m_addr, m_wstrb} !== {3'b110, 32'h100, 4'h0}) begin
            failures++; $display("FAIL fetch_ireq got=%b_%h exp=110_00000100", {m_req_valid, i_req_ready, m_wen}, m_addr); end
        step(); i_req_valid = 0; #1;
        checks++; if ({i_rdata_valid, m_rdata_ready, d_rdata_valid, m_req_valid} !== 4'b1100 || i_rdata !== 32'h2402000A) begin
            failures++; $display("FAIL fetch_iresp got=%b data=%h exp=1100 data=2402000a", {i_rdata_valid, m_rdata_ready, d_rdata_valid, m_req_valid}, i_rdata); end
        step(); #1;
        checks++; if ({m_req_valid, i_rdata_valid, m_rdata_ready} !== 3'b000) begin
            failures++; $display("FAIL fetch_back_idle got=%b exp=000", {m_req_valid, i_rdata_valid, m_rdata_ready}); end
        idle_inputs();
    endtask

    task automatic test_store_wait();
        d_req_valid = 1; d_wen = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        m_req_ready = 0;
        step();
        for (int c = 0; c < 4; c++) begin
            m_req_ready = (c == 3); #1;
            checks++; if ({m_req_valid, m_wen, d_req_ready} !== {2'b11, (c == 3)} ||
                          m_addr !== 32'h200 || m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'hF) begin
                failures++; $display("FAIL store_dreq cyc=%0d got=%b %h %h %h", c, {m_req_valid, m_wen, d_req_ready}, m_addr, m_wdata, m_wstrb); end
            step();
        end
        d_req_valid = 0; m_req_ready = 0; m_rdata_valid = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if ({m_req_valid, d_rdata_valid, m_rdata_ready} !== 3'b000) begin
                failures++; $display("FAIL store_no_resp cyc=%0d got=%b exp=000", c, {m_req_valid, d_rdata_valid, m_rdata_ready}); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        i_req_valid = 1; i_addr = 32'h300; d_req_valid = 1; d_wen = 0; d_addr = 32'h400;
        m_req_ready = 1; m_rdata_valid = 1; m_rdata = 32'h11111111;
        step(); #1;
        checks++; if ({d_req_ready, i_req_ready} !== 2'b10 || m_addr !== 32'h400) begin
            failures++; $display("FAIL simul_load_first got=%b %h exp=10 00000400", {d_req_ready, i_req_ready}, m_addr); end
        step(); d_req_valid = 0; #1;
        checks++; if ({d_rdata_valid, i_rdata_valid} !== 2'b10 || d_rdata !== 32'h11111111) begin
            failures++; $display("FAIL simul_dresp got=%b %h exp=10 11111111", {d_rdata_valid, i_rdata_valid}, d_rdata); end
        step(); step(); #1;
        checks++; if ({i_req_ready, d_req_ready} !== 2'b10 || m_addr !== 32'h300) begin
            failures++; $display("FAIL simul_fetch_second got=%b %h exp=10 00000300", {i_req_ready, d_req_ready}, m_addr); end
        step(); i_req_valid = 0; #1;
        checks++; if (i_rdata_valid !== 1'b1) begin
            failures++; $display("FAIL simul_iresp got=%b exp=1", i_rdata_valid); end
        step();
        idle_inputs();
    endtask

    task automatic test_starvation();
        bit exp_fetch;
        i_req_valid = 1; i_addr = 32'h500; d_req_valid = 1; d_wen = 0;
        m_req_ready = 1; m_rdata_valid = 1; m_rdata = 32'hCAFE0000;
        for (int g = 1; g <= 6; g++) begin
            exp_fetch = (g == 5);
            d_addr = 32'h600 + 32'(g * 4); #1;
            checks++; if (m_req_valid !== 1'b0) begin
                failures++; $display("FAIL starve_idle g=%0d got=%b exp=0", g, m_req_valid); end
            step(); #1;
            checks++; if ({i_req_ready, d_req_ready} !== {exp_fetch, !exp_fetch} ||
                          m_addr !== (exp_fetch ? 32'h500 : d_addr)) begin
                failures++; $display("FAIL starve_grant g=%0d got=%b %h exp=%b", g, {i_req_ready, d_req_ready}, m_addr, {exp_fetch, !exp_fetch}); end
            step(); #1;
            checks++; if ({i_rdata_valid, d_rdata_valid} !== {exp_fetch, !exp_fetch}) begin
                failures++; $display("FAIL starve_resp g=%0d got=%b exp=%b", g, {i_rdata_valid, d_rdata_valid}, {exp_fetch, !exp_fetch}); end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        d_req_valid = 1; d_wen = 0; d_addr = 32'h700; m_req_ready = 1; m_rdata_valid = 0;
        step(); step(); d_req_valid = 0; #1;
        checks++; if ({d_rdata_valid, m_rdata_ready} !== 2'b01) begin
            failures++; $display("FAIL mid_dresp_wait got=%b exp=01", {d_rdata_valid, m_rdata_ready}); end
        rst = 1; m_rdata_valid = 1; m_rdata = 32'h77777777;
        step(); rst = 0; #1;
        checks++; if ({m_req_valid, m_wen, i_req_ready, d_req_ready, i_rdata_valid, d_rdata_valid, m_rdata_ready} !== 7'b0 ||
                      {m_addr, m_wdata, m_wstrb, i_rdata, d_rdata} !== 132'h0) begin
            failures++; $display("FAIL mid_reset_outputs got=%b %h exp=0", {m_req_valid, m_wen, i_req_ready, d_req_ready, i_rdata_valid, d_rdata_valid, m_rdata_ready}, m_addr); end
        i_req_valid = 1; i_addr = 32'h800; m_rdata = 32'h88888888;
        step(); #1;
        checks++; if ({i_req_ready, m_req_valid} !== 2'b11 || m_addr !== 32'h800) begin
            failures++; $display("FAIL mid_new_fetch got=%b %h exp=11 00000800", {i_req_ready, m_req_valid}, m_addr); end
        step(); i_req_valid = 0; #1;
        checks++; if (i_rdata_valid !== 1'b1 || i_rdata !== 32'h88888888) begin
            failures++; $display("FAIL mid_fetch_resp got=%b %h exp=1 88888888", i_rdata_valid, i_rdata); end
        step();
        idle_inputs();
    endtask

`ifdef MEM_ARB_PERF_CNT_EN
    task automatic test_perf();
        idle_inputs(); rst = 1; step(); rst = 0;
        checks++; if ({perf_i_grant, perf_d_grant, perf_conflict} !== 96'h0) begin
            failures++; $display("FAIL perf_reset got=%h %h %h exp=0", perf_i_grant, perf_d_grant, perf_conflict); end
        m_req_ready = 1; m_rdata_valid = 1;
        for (int t = 0; t < 5; t++) begin
            i_req_valid = (t < 3); d_req_valid = (t >= 3); i_addr = 32'h900; d_addr = 32'hA00;
            step(); step(); i_req_valid = 0; d_req_valid = 0; step();
        end
        #1;
        checks++; if (perf_i_grant !== 32'd3 || perf_d_grant !== 32'd2) begin
            failures++; $display("FAIL perf_grants got=%0d/%0d exp=3/2", perf_i_grant, perf_d_grant); end
        checks++; if (perf_conflict == 32'd0) begin
            failures++; $display("FAIL perf_conflict got=0 exp=nonzero"); end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_store_wait();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
`ifdef MEM_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
